// File: rtl/secded_pkg.sv
// Shared types and helpers for the extended-Hamming SEC-DED stream decoder.
// Holds parity-width sizing and the Hamming position to data-index mapping.
package secded_pkg;

    typedef enum logic [1:0] {
        CLEAN,
        SINGLE,
        UNCORR
    } err_class_e;

    // Smallest r with 2^r >= data_w + r + 1.
    function automatic int secded_par_w(input int data_w);
        int r;
        r = 0;
        for (int k = 7; k >= 1; k--) begin
            if ((1 << k) >= data_w + k + 1) begin
                r = k;
            end
        end
        return r;
    endfunction

    // Power-of-two Hamming positions hold parity bits.
    function automatic bit secded_is_par(input int pos);
        return (pos & (pos - 1)) == 0;
    endfunction

    // Data index carried by a non-parity Hamming position (LSB-first).
    function automatic int secded_data_idx(input int pos);
        int n;
        n = 0;
        for (int j = 0; j < 7; j++) begin
            if ((1 << j) <= pos) begin
                n++;
            end
        end
        return pos - n - 1;
    endfunction

endpackage

// File: rtl/secded_stream_decoder_if.sv
// Codeword input stream and decoded-word output stream of the decoder.
// The decoder takes the slave view, its feeder/consumer the master view.
interface secded_stream_decoder_if
    import secded_pkg::*;
#(
    parameter int DATA_W = 8
) ();
    localparam int PAR_W  = secded_par_w(DATA_W);
    localparam int CODE_W = DATA_W + PAR_W + 1;

    logic              s_valid;
    logic              s_ready;
    logic [CODE_W-1:0] s_code;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_single_err;
    logic              m_uncorr;
    logic [PAR_W-1:0]  m_syndrome;

    modport slave (
        input  s_valid, s_code, m_ready,
        output s_ready, m_valid, m_data,
        output m_single_err, m_uncorr, m_syndrome
    );

    modport master (
        output s_valid, s_code, m_ready,
        input  s_ready, m_valid, m_data,
        input  m_single_err, m_uncorr, m_syndrome
    );

endinterface

// File: rtl/secded_syndrome.sv
// Combinational Hamming syndrome and overall parity of one codeword.
// Shared with the encoder self-check path.
module secded_syndrome #(
    parameter int CODE_W = 13,
    parameter int PAR_W  = 4
) (
    input  logic [CODE_W-1:0] code,
    output logic [PAR_W-1:0]  syn,
    output logic              par
);

    // Syndrome bit j folds every position whose index has bit j set.
    always_comb begin
        syn = '0;
        for (int i = 0; i < CODE_W - 1; i++) begin
            for (int j = 0; j < PAR_W; j++) begin
                if ((((i + 1) >> j) & 1) != 0) begin
                    syn[j] = syn[j] ^ code[i];
                end
            end
        end
        par = ^code;
    end

endmodule

// File: rtl/secded_stream_decoder.sv
// Two-stage pipelined SEC-DED decoder on a valid/ready stream.
// S1 holds codeword + syndrome, S2 holds corrected data and error flags.
module secded_stream_decoder
    import secded_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             corr_en,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] cnt_single,
    output logic [CNT_W-1:0] cnt_uncorr,
    secded_stream_decoder_if.slave bus
);

    localparam int PAR_W  = secded_par_w(DATA_W);
    localparam int CODE_W = DATA_W + PAR_W + 1;

    logic              s1_valid_q, s1_valid_d;
    logic [CODE_W-1:0] s1_code_q, s1_code_d;
    logic [PAR_W-1:0]  s1_syn_q, s1_syn_d;
    logic              s1_par_q, s1_par_d;

    logic              m_valid_q, m_valid_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic              m_single_err_q, m_single_err_d;
    logic              m_uncorr_q, m_uncorr_d;
    logic [PAR_W-1:0]  m_syndrome_q, m_syndrome_d;

    logic [CNT_W-1:0]  cnt_single_q, cnt_single_d;
    logic [CNT_W-1:0]  cnt_uncorr_q, cnt_uncorr_d;

    logic              in_par;
    logic [PAR_W-1:0]  in_syn;
    logic              s1_adv;
    logic              s2_adv;
    logic              out_hs;
    err_class_e        cls;
    logic [CODE_W-1:0] fix_code;
    logic [DATA_W-1:0] fix_data;

    secded_syndrome #(
        .CODE_W (CODE_W),
        .PAR_W  (PAR_W)
    ) u_syndrome (
        .code (bus.s_code),
        .syn  (in_syn),
        .par  (in_par)
    );

    assign s2_adv      = !m_valid_q || bus.m_ready;
    assign s1_adv      = !s1_valid_q || s2_adv;
    assign out_hs      = m_valid_q && bus.m_ready;
    assign bus.s_ready = s1_adv;

    // S1 next state: take a new codeword whenever S1 can move on.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_code_d  = s1_code_q;
        s1_syn_d   = s1_syn_q;
        s1_par_d   = s1_par_q;
        if (s1_adv) begin
            s1_valid_d = bus.s_valid;
            if (bus.s_valid) begin
                s1_code_d = bus.s_code;
                s1_syn_d  = in_syn;
                s1_par_d  = in_par;
            end
        end
    end

    // Error class from syndrome and overall parity held in S1.
    always_comb begin
        cls = CLEAN;
        if (!s1_par_q) begin
            cls = (s1_syn_q == '0) ? CLEAN : UNCORR;
        end else if (int'(s1_syn_q) > CODE_W - 1) begin
            cls = UNCORR;
        end else begin
            cls = SINGLE;
        end
    end

    // Flip the flagged position when enabled, then pull out data bits.
    always_comb begin
        fix_code = s1_code_q;
        for (int i = 0; i < CODE_W - 1; i++) begin
            if (cls == SINGLE && corr_en && int'(s1_syn_q) == i + 1) begin
                fix_code[i] = ~fix_code[i];
            end
        end
        fix_data = '0;
        for (int p = 1; p < CODE_W; p++) begin
            if (!secded_is_par(p)) begin
                fix_data[secded_data_idx(p)] = fix_code[p - 1];
            end
        end
    end

    // S2 next state: output word holds until accepted downstream.
    always_comb begin
        m_valid_d      = m_valid_q;
        m_data_d       = m_data_q;
        m_single_err_d = m_single_err_q;
        m_uncorr_d     = m_uncorr_q;
        m_syndrome_d   = m_syndrome_q;
        if (s2_adv) begin
            m_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                m_data_d       = fix_data;
                m_single_err_d = (cls == SINGLE);
                m_uncorr_d     = (cls == UNCORR);
                m_syndrome_d   = s1_syn_q;
            end
        end
    end

    // Saturating error counters; clear beats a same-cycle increment.
    always_comb begin
        cnt_single_d = cnt_single_q;
        cnt_uncorr_d = cnt_uncorr_q;
        if (cnt_clr) begin
            cnt_single_d = '0;
            cnt_uncorr_d = '0;
        end else if (out_hs) begin
            if (m_single_err_q && cnt_single_q != '1) begin
                cnt_single_d = cnt_single_q + CNT_W'(1);
            end
            if (m_uncorr_q && cnt_uncorr_q != '1) begin
                cnt_uncorr_d = cnt_uncorr_q + CNT_W'(1);
            end
        end
    end

    // S1 pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_code_q  <= '0;
            s1_syn_q   <= '0;
            s1_par_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_code_q  <= s1_code_d;
            s1_syn_q   <= s1_syn_d;
            s1_par_q   <= s1_par_d;
        end
    end

    // S2 pipeline register, drives the output stream directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q      <= 1'b0;
            m_data_q       <= '0;
            m_single_err_q <= 1'b0;
            m_uncorr_q     <= 1'b0;
            m_syndrome_q   <= '0;
        end else begin
            m_valid_q      <= m_valid_d;
            m_data_q       <= m_data_d;
            m_single_err_q <= m_single_err_d;
            m_uncorr_q     <= m_uncorr_d;
            m_syndrome_q   <= m_syndrome_d;
        end
    end

    // Error counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_single_q <= '0;
            cnt_uncorr_q <= '0;
        end else begin
            cnt_single_q <= cnt_single_d;
            cnt_uncorr_q <= cnt_uncorr_d;
        end
    end

    assign bus.m_valid      = m_valid_q;
    assign bus.m_data       = m_data_q;
    assign bus.m_single_err = m_single_err_q;
    assign bus.m_uncorr     = m_uncorr_q;
    assign bus.m_syndrome   = m_syndrome_q;
    assign cnt_single       = cnt_single_q;
    assign cnt_uncorr       = cnt_uncorr_q;

endmodule

// File: tb/tb_secded_stream_decoder.sv
// Bench for secded_stream_decoder: directed 4-bit vectors plus a random
// 8-bit stream under backpressure, checked against an index-XOR model.
module tb_secded_stream_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        corr_a, clr_a, corr_b, clr_b;
    logic [1:0]  cs_a, cu_a;
    logic [15:0] cs_b, cu_b;

    int vecs  = 0;
    int fails = 0;

    always #5 clk = ~clk;

    secded_stream_decoder_if #(.DATA_W(4)) bus_a ();
    secded_stream_decoder_if #(.DATA_W(8)) bus_b ();

    secded_stream_decoder #(.DATA_W(4), .CNT_W(2)) u_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .corr_en    (corr_a),
        .cnt_clr    (clr_a),
        .cnt_single (cs_a),
        .cnt_uncorr (cu_a),
        .bus        (bus_a)
    );

    secded_stream_decoder #(.DATA_W(8), .CNT_W(16)) u_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .corr_en    (corr_b),
        .cnt_clr    (clr_b),
        .cnt_single (cs_b),
        .cnt_uncorr (cu_b),
        .bus        (bus_b)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        vecs++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Hamming encode: data into non-power-of-two positions, parity from
    // the XOR of the indices of set data positions.
    function automatic logic [63:0] ref_encode(input logic [63:0] d,
                                               input int cw);
        logic [63:0] c;
        int k, s;
        c = '0;
        k = 0;
        s = 0;
        for (int p = 1; p < cw; p++) begin
            if ((p & (p - 1)) != 0) begin
                c[p - 1] = d[k];
                if (d[k]) s = s ^ p;
                k++;
            end
        end
        for (int j = 0; j < 7; j++) begin
            if ((1 << j) < cw) c[(1 << j) - 1] = ((s >> j) & 1) != 0;
        end
        c[cw - 1] = ($countones(c) % 2) != 0;
        return c;
    endfunction

    function automatic void ref_decode(input logic [63:0] code,
                                       input int cw, input bit corr,
                                       output logic [63:0] data,
                                       output bit single, output bit unc,
                                       output int syn);
        logic [63:0] c;
        bit par;
        int k;
        c = code;
        syn = 0;
        for (int p = 1; p < cw; p++) begin
            if (c[p - 1]) syn = syn ^ p;
        end
        par = ($countones(c) % 2) != 0;
        single = par && (syn <= cw - 1);
        unc = (!par && syn != 0) || (par && syn > cw - 1);
        if (single && corr && syn != 0) c[syn - 1] = ~c[syn - 1];
        data = '0;
        k = 0;
        for (int p = 1; p < cw; p++) begin
            if ((p & (p - 1)) != 0) begin
                data[k] = c[p - 1];
                k++;
            end
        end
    endfunction

    task automatic xfer_a(input logic [7:0] code, input logic corr,
                          input logic clr, output logic [3:0] d,
                          output logic s, output logic u,
                          output logic [2:0] syn);
        int n;
        @(negedge clk);
        corr_a = corr;
        bus_a.s_code = code;
        bus_a.s_valid = 1'b1;
        #1 chk("a_s_ready", bus_a.s_ready, 1);
        @(negedge clk);
        bus_a.s_valid = 1'b0;
        chk("a_not_yet_valid", bus_a.m_valid, 0);
        n = 0;
        while (!bus_a.m_valid && n < 4) begin
            @(negedge clk);
            n++;
        end
        chk("a_latency", n, 1);
        d = bus_a.m_data;
        s = bus_a.m_single_err;
        u = bus_a.m_uncorr;
        syn = bus_a.m_syndrome;
        clr_a = clr;
        @(negedge clk);
        clr_a = 1'b0;
    endtask

    logic [3:0]  d4;
    logic        s4, u4;
    logic [2:0]  y4;
    logic [63:0] c64, ed;
    bit          es, eu;
    int          ey, n, p, got, exp_sb, exp_ub, seen;
    logic [63:0] codes [20];
    logic [63:0] q [$];
    logic        prev_stall;
    logic [7:0]  prev_d;
    logic [3:0]  prev_y;
    logic        prev_s, prev_u;

    initial begin
        bus_a.s_valid = 1'b0;
        bus_a.s_code  = '0;
        bus_a.m_ready = 1'b1;
        bus_b.s_valid = 1'b0;
        bus_b.s_code  = '0;
        bus_b.m_ready = 1'b0;
        corr_a = 1'b1;
        clr_a  = 1'b0;
        corr_b = 1'b1;
        clr_b  = 1'b0;
        exp_sb = 0;
        exp_ub = 0;

        repeat (3) @(negedge clk);
        chk("rst_m_valid", bus_a.m_valid, 0);
        chk("rst_m_data", bus_b.m_data, 0);
        chk("rst_flags", {bus_a.m_single_err, bus_a.m_uncorr}, 0);
        chk("rst_syn", bus_b.m_syndrome, 0);
        chk("rst_cnt", {cs_a, cu_a, cs_b, cu_b}, 0);
        rst_n = 1'b1;
        #1 chk("rst_s_ready", bus_b.s_ready, 1);

        xfer_a(8'h55, 1'b1, 1'b0, d4, s4, u4, y4);
        chk("clean_data", d4, 4'hB);
        chk("clean_flags", {s4, u4, y4}, 0);
        chk("clean_cnt", cs_a, 0);

        xfer_a(8'h45, 1'b1, 1'b0, d4, s4, u4, y4);
        chk("sec_data", d4, 4'hB);
        chk("sec_flags", {s4, u4}, 2'b10);
        chk("sec_syn", y4, 5);
        chk("sec_cnt", cs_a, 1);

        xfer_a(8'h45, 1'b0, 1'b0, d4, s4, u4, y4);
        chk("detect_only_data", d4, 4'h9);
        chk("detect_only_single", s4, 1);

        xfer_a(8'hD5, 1'b1, 1'b0, d4, s4, u4, y4);
        chk("ovp_data", d4, 4'hB);
        chk("ovp_flags", {s4, u4, y4}, 5'b10000);

        xfer_a(8'h56, 1'b1, 1'b0, d4, s4, u4, y4);
        chk("ded_flags", {s4, u4}, 2'b01);
        chk("ded_cnt_u", cu_a, 1);
        chk("ded_cnt_s", cs_a, 3);

        xfer_a(8'h45, 1'b1, 1'b0, d4, s4, u4, y4);
        xfer_a(8'h45, 1'b1, 1'b0, d4, s4, u4, y4);
        chk("sat_cnt", cs_a, 3);
        xfer_a(8'h45, 1'b1, 1'b1, d4, s4, u4, y4);
        chk("clr_wins_s", cs_a, 0);
        chk("clr_wins_u", cu_a, 0);

        c64 = ref_encode(64'hA7, 13);
        c64[0] = ~c64[0];
        c64[3] = ~c64[3];
        c64[7] = ~c64[7];
        @(negedge clk);
        bus_b.m_ready = 1'b1;
        bus_b.s_code = c64[12:0];
        bus_b.s_valid = 1'b1;
        @(negedge clk);
        bus_b.s_valid = 1'b0;
        n = 0;
        while (!bus_b.m_valid && n < 4) begin
            @(negedge clk);
            n++;
        end
        chk("oor_uncorr", {bus_b.m_single_err, bus_b.m_uncorr}, 2'b01);
        chk("oor_syn", bus_b.m_syndrome, 13);
        chk("oor_data", bus_b.m_data, 8'hA7);
        exp_ub++;
        @(negedge clk);

        for (int i = 0; i < 20; i++) begin
            c64 = ref_encode(64'($urandom & 32'hFF), 13);
            n = $urandom_range(0, 2);
            for (int f = 0; f < n; f++) begin
                ey = $urandom_range(0, 12);
                c64[ey] = ~c64[ey];
            end
            codes[i] = c64;
        end
        p = 0;
        got = 0;
        prev_stall = 1'b0;
        for (int cyc = 0; cyc < 400 && got < 20; cyc++) begin
            @(negedge clk);
            if (prev_stall) begin
                chk("hold_valid", bus_b.m_valid, 1);
                chk("hold_payload",
                    {bus_b.m_data, bus_b.m_syndrome,
                     bus_b.m_single_err, bus_b.m_uncorr},
                    {prev_d, prev_y, prev_s, prev_u});
            end
            bus_b.m_ready = (cyc >= 6 && cyc <= 10) ? 1'b0
                                                    : 1'($urandom_range(0, 1));
            if (p < 20) begin
                bus_b.s_valid = 1'b1;
                bus_b.s_code = codes[p][12:0];
            end else begin
                bus_b.s_valid = 1'b0;
            end
            #1;
            if (cyc == 10) chk("full_s_ready", bus_b.s_ready, 0);
            if (bus_b.s_valid && bus_b.s_ready) begin
                q.push_back(codes[p]);
                p++;
            end
            if (bus_b.m_valid && bus_b.m_ready) begin
                if (q.size() == 0) begin
                    chk("extra_word", 1, 0);
                end else begin
                    c64 = q.pop_front();
                    ref_decode(c64, 13, 1'b1, ed, es, eu, ey);
                    chk("str_data", bus_b.m_data, ed);
                    chk("str_flags", {bus_b.m_single_err, bus_b.m_uncorr},
                        {es, eu});
                    chk("str_syn", bus_b.m_syndrome, ey);
                    if (es) exp_sb++;
                    if (eu) exp_ub++;
                end
                got++;
            end
            prev_stall = bus_b.m_valid && !bus_b.m_ready;
            prev_d = bus_b.m_data;
            prev_y = bus_b.m_syndrome;
            prev_s = bus_b.m_single_err;
            prev_u = bus_b.m_uncorr;
        end
        chk("str_count", got, 20);
        @(negedge clk);
        bus_b.s_valid = 1'b0;
        chk("str_cnt_single", cs_b, exp_sb);
        chk("str_cnt_uncorr", cu_b, exp_ub);

        bus_a.m_ready = 1'b0;
        bus_a.s_code = 8'h45;
        bus_a.s_valid = 1'b1;
        n = 0;
        while (!bus_a.m_valid && n < 6) begin
            @(negedge clk);
            n++;
        end
        chk("pre_rst_valid", bus_a.m_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid_a", bus_a.m_valid, 0);
        chk("mid_rst_cnt_b", cs_b, 0);
        bus_a.s_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus_a.m_ready = 1'b1;
        #1 chk("post_rst_s_ready", bus_a.s_ready, 1);
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus_a.m_valid) seen++;
        end
        chk("rst_drops_inflight", seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
